// File: rtl/counter_arbiter.sv
// Round-robin arbiter that shares one external up/down counter between NREQ requesters.
// Each grant runs one load/up/down/read command on the counter and returns the final count.
module counter_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LENW  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [2*NREQ-1:0]      req_op,
  input  logic [WIDTH*NREQ-1:0]  req_data,
  input  logic [LENW*NREQ-1:0]   req_len,
  output logic [NREQ-1:0]        resp_valid,
  output logic [WIDTH-1:0]       resp_data,
  output logic                   busy,
  output logic                   cnt_load,
  output logic [WIDTH-1:0]       cnt_loaddata,
  output logic                   cnt_en,
  output logic                   cnt_updwn,
  input  logic [WIDTH-1:0]       cnt_count
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [LENW-1:0]  len_q, len_d;

  logic             found;
  logic [IW-1:0]    win;
  logic [IW-1:0]    cand;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_data;
  logic [LENW-1:0]  sel_len;
  logic             accept;
  logic             exec_ld;
  logic             exec_cnt;

  // Search starts just after the last winner so every pending requester gets a turn.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      cand = IW'((int'(ptr_q) + k) % int'(NREQ));
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    sel_op   = '0;
    sel_data = '0;
    sel_len  = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (win == IW'(i)) begin
        sel_op   = req_op[2*i +: 2];
        sel_data = req_data[WIDTH*i +: WIDTH];
        sel_len  = req_len[LENW*i +: LENW];
      end
    end
  end

  assign accept = (state_q == IDLE) && found;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    op_d    = op_q;
    data_d  = data_q;
    len_d   = len_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          ptr_d  = win;
          idx_d  = win;
          op_d   = sel_op;
          data_d = sel_data;
          len_d  = sel_len;
          if (sel_op == OP_LOAD ||
              ((sel_op == OP_UP || sel_op == OP_DOWN) && sel_len != '0)) begin
            state_d = EXEC;
          end else begin
            state_d = RESP;
          end
        end
      end
      EXEC: begin
        // len_q counts the remaining enable cycles, including the current one.
        if (op_q == OP_LOAD || len_q <= LENW'(1)) begin
          state_d = RESP;
        end else begin
          len_d = len_q - LENW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= IW'(NREQ - 1);
      idx_q   <= '0;
      op_q    <= '0;
      data_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      data_q  <= data_d;
      len_q   <= len_d;
    end
  end

  assign exec_ld  = (state_q == EXEC) && (op_q == OP_LOAD);
  assign exec_cnt = (state_q == EXEC) && (op_q == OP_UP || op_q == OP_DOWN);

  assign cnt_load     = exec_ld;
  assign cnt_loaddata = exec_ld ? data_q : '0;
  assign cnt_en       = exec_cnt;
  assign cnt_updwn    = exec_cnt && (op_q == OP_UP);
  assign busy         = (state_q != IDLE);
  assign resp_data    = (state_q == RESP) ? cnt_count : '0;

  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      req_ready[i]  = accept && (win == IW'(i));
      resp_valid[i] = (state_q == RESP) && (idx_q == IW'(i));
    end
  end

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed and randomised checks of counter_arbiter driving a behavioural up/down counter.
module tb_counter_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned LENW  = 8;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [2*NREQ-1:0]     req_op = '0;
  logic [WIDTH*NREQ-1:0] req_data = '0;
  logic [LENW*NREQ-1:0]  req_len = '0;
  logic [NREQ-1:0]       resp_valid;
  logic [WIDTH-1:0]      resp_data;
  logic                  busy;
  logic                  cnt_load;
  logic [WIDTH-1:0]      cnt_loaddata;
  logic                  cnt_en;
  logic                  cnt_updwn;
  logic [WIDTH-1:0]      cnt_count = '0;

  int checks = 0;
  int errors = 0;
  logic [31:0] model = '0;

  always #5 clk = ~clk;

  // External counter: no reset, load has priority over enable.
  always @(posedge clk) begin
    if (cnt_load) cnt_count <= cnt_loaddata;
    else if (cnt_en) cnt_count <= cnt_updwn ? cnt_count + 32'd1 : cnt_count - 32'd1;
  end

  counter_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .LENW(LENW)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_data     (req_data),
    .req_len      (req_len),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .busy         (busy),
    .cnt_load     (cnt_load),
    .cnt_loaddata (cnt_loaddata),
    .cnt_en       (cnt_en),
    .cnt_updwn    (cnt_updwn),
    .cnt_count    (cnt_count)
  );

  typedef struct {
    int unsigned r;
    logic [1:0]  op;
    logic [31:0] data;
    logic [7:0]  len;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Issue one command and follow it to its response, checking drive pins on the way.
  task automatic do_cmd(input int unsigned r, input logic [1:0] op, input logic [31:0] data,
                        input logic [7:0] len, input logic [31:0] exp, input int lat);
    logic [3:0] oh;
    int ens, lds, cyc;
    bit done;
    oh = 4'b0001 << r;
    @(posedge clk); #1;
    check("idle_busy", {63'd0, busy}, 64'd0);
    req_valid = oh;
    req_op[2*r +: 2] = op;
    req_data[32*r +: 32] = data;
    req_len[8*r +: 8] = len;
    #1;
    check("accept_ready", {60'd0, req_ready}, {60'd0, oh});
    @(posedge clk); #1;
    req_valid = '0;
    cyc = 1; ens = 0; lds = 0; done = 1'b0;
    while (!done && cyc < 400) begin
      check("load_en_excl", {63'd0, cnt_load & cnt_en}, 64'd0);
      check("ready_quiet", {60'd0, req_ready}, 64'd0);
      check("busy", {63'd0, busy}, 64'd1);
      if (cnt_en) begin
        ens++;
        check("updwn", {63'd0, cnt_updwn}, {63'd0, op == 2'b01});
      end
      if (cnt_load) begin
        lds++;
        check("loaddata", {32'd0, cnt_loaddata}, {32'd0, data});
      end
      if (resp_valid != '0) begin
        done = 1'b1;
        check("resp_onehot", {60'd0, resp_valid}, {60'd0, oh});
        check("resp_data", {32'd0, resp_data}, {32'd0, exp});
        check("latency", 64'(cyc), 64'(lat));
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    check("resp_seen", {63'd0, done}, 64'd1);
    check("en_cycles", 64'(ens), (op == 2'b01 || op == 2'b10) ? 64'(len) : 64'd0);
    check("load_cycles", 64'(lds), (op == 2'b00) ? 64'd1 : 64'd0);
    model = exp;
  endtask

  initial begin
    int order[6];
    int g, last, pend;
    logic [1:0]  rop;
    logic [31:0] rdata, rexp;
    logic [7:0]  rlen;
    int unsigned rr;
    int rlat;

    vecs[0] = '{0, 2'b00, 32'h0000_0010, 8'd0,   32'h0000_0010, 2};
    vecs[1] = '{1, 2'b01, 32'h0,         8'd5,   32'h0000_0015, 6};
    vecs[2] = '{3, 2'b00, 32'h0000_0002, 8'd0,   32'h0000_0002, 2};
    vecs[3] = '{2, 2'b10, 32'h0,         8'd4,   32'hFFFF_FFFE, 5};
    vecs[4] = '{1, 2'b01, 32'h0,         8'd0,   32'hFFFF_FFFE, 1};
    vecs[5] = '{3, 2'b11, 32'h0,         8'd0,   32'hFFFF_FFFE, 1};
    vecs[6] = '{0, 2'b01, 32'h0,         8'd3,   32'h0000_0001, 4};
    vecs[7] = '{2, 2'b00, 32'hDEAD_BEEF, 8'd0,   32'hDEAD_BEEF, 2};
    vecs[8] = '{1, 2'b10, 32'h0,         8'd0,   32'hDEAD_BEEF, 1};
    vecs[9] = '{0, 2'b10, 32'h0,         8'd255, 32'hDEAD_BDF0, 256};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {60'd0, req_ready}, 64'd0);
    check("rst_resp_valid", {60'd0, resp_valid}, 64'd0);
    check("rst_resp_data", {32'd0, resp_data}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_load", {63'd0, cnt_load}, 64'd0);
    check("rst_en", {63'd0, cnt_en}, 64'd0);
    check("rst_updwn", {63'd0, cnt_updwn}, 64'd0);
    check("rst_loaddata", {32'd0, cnt_loaddata}, 64'd0);
    reset = 1'b0;

    // Directed vectors
    for (int i = 0; i < 10; i++)
      do_cmd(vecs[i].r, vecs[i].op, vecs[i].data, vecs[i].len, vecs[i].exp, vecs[i].lat);

    // All requesters reading continuously after reset
    do_reset();
    order = '{0, 1, 2, 3, 0, 1};
    g = 0; last = -2; pend = 0;
    @(posedge clk); #1;
    req_valid = 4'hF;
    req_op = 8'hFF;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (pend != 0) begin
        check("rr_resp", {60'd0, resp_valid}, 64'(pend));
        check("rr_data", {32'd0, resp_data}, {32'd0, model});
        pend = 0;
      end else begin
        check("rr_noresp", {60'd0, resp_valid}, 64'd0);
      end
      if (req_ready != '0) begin
        if (g < 6) check("rr_grant", {60'd0, req_ready}, 64'(4'b0001 << order[g]));
        check("rr_spacing", 64'(c - last), 64'd2);
        last = c;
        pend = int'(req_ready);
        g++;
      end
      @(posedge clk); #1;
    end
    check("rr_grants", 64'(g), 64'd6);
    req_valid = '0;

    // Reset during the third enable cycle of an up-10 command
    @(posedge clk); #1;
    req_valid = 4'b0010;
    req_op[3:2] = 2'b01;
    req_len[15:8] = 8'd10;
    #1;
    check("r5_ready", {60'd0, req_ready}, 64'h2);
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("r5_en_c3", {63'd0, cnt_en}, 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model = model + 32'd3;
    check("r5_busy", {63'd0, busy}, 64'd0);
    check("r5_en", {63'd0, cnt_en}, 64'd0);
    check("r5_updwn", {63'd0, cnt_updwn}, 64'd0);
    check("r5_load", {63'd0, cnt_load}, 64'd0);
    check("r5_resp_valid", {60'd0, resp_valid}, 64'd0);
    check("r5_resp_data", {32'd0, resp_data}, 64'd0);
    @(posedge clk); #1;
    check("r5_no_resp", {60'd0, resp_valid}, 64'd0);
    req_valid = 4'hF;
    req_op = 8'hFF;
    #1;
    check("r5_first_grant", {60'd0, req_ready}, 64'h1);
    @(posedge clk); #1;
    req_valid = '0;
    check("r5_read_valid", {60'd0, resp_valid}, 64'h1);
    check("r5_read_data", {32'd0, resp_data}, {32'd0, model});

    // Random commands against the reference count
    for (int n = 0; n < 40; n++) begin
      rr    = $urandom_range(0, 3);
      rop   = 2'($urandom_range(0, 3));
      rdata = $urandom;
      rlen  = 8'($urandom_range(0, 12));
      case (rop)
        2'b00:   begin rexp = rdata;                 rlat = 2; end
        2'b01:   begin rexp = model + 32'(rlen);     rlat = (rlen == 0) ? 1 : int'(rlen) + 1; end
        2'b10:   begin rexp = model - 32'(rlen);     rlat = (rlen == 0) ? 1 : int'(rlen) + 1; end
        default: begin rexp = model;                 rlat = 1; end
      endcase
      do_cmd(rr, rop, rdata, rlen, rexp, rlat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
